// File: rtl/resample_pkg.sv
// Shared constants and state encoding for the ping-pong resample frame scheduler.
package resample_pkg;

   localparam int XK_WIDTH_D      = 12;
   localparam int SF_INT_WIDTH_D  = 4;
   localparam int SF_FRAC_WIDTH_D = 16;
   localparam int DFT_WIDTH_D     = 24;

   localparam int SF_WIDTH_D  = SF_INT_WIDTH_D + SF_FRAC_WIDTH_D;
   localparam int PROD_WIDTH_D = XK_WIDTH_D + SF_WIDTH_D;

   // Unity scale factor for a given fraction width
   function automatic longint unsigned sf_one(input int frac_width);
      return 64'd1 << frac_width;
   endfunction

   typedef enum logic [1:0] {
      RD_IDLE  = 2'd0,
      RD_RUN   = 2'd1,
      RD_DRAIN = 2'd2
   } rd_state_t;

endpackage

// File: rtl/resample_frame_sched_if.sv
// Input-bin stream, scale-factor strobe and output stream of the frame scheduler.
interface resample_frame_sched_if #(
   parameter int DFT_WIDTH = 24,
   parameter int SF_WIDTH  = 20
);
   logic [SF_WIDTH-1:0]  scale_factor;
   logic                 scale_factor_valid;
   logic [DFT_WIDTH-1:0] fft_data;
   logic                 fft_valid;
   logic                 fft_last;
   logic                 fft_ready;
   logic [DFT_WIDTH-1:0] m_data;
   logic                 m_valid;
   logic                 m_last;
   logic                 m_ready;

   modport master (
      output scale_factor, scale_factor_valid, fft_data, fft_valid, fft_last, m_ready,
      input  fft_ready, m_data, m_valid, m_last
   );

   modport slave (
      input  scale_factor, scale_factor_valid, fft_data, fft_valid, fft_last, m_ready,
      output fft_ready, m_data, m_valid, m_last
   );
endinterface

// File: rtl/bin_ram.sv
// Simple dual-port bin store, address {bank, index}, registered read with enable.
module bin_ram #(
   parameter int AW = 13,
   parameter int DW = 24
) (
   input  logic          clock,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic          i_re,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_q
);
   logic [DW-1:0] r_mem [2**AW];
   logic [DW-1:0] r_q;

   always_ff @(posedge clock) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      if (i_re) r_q <= r_mem[i_raddr];
   end

   assign o_q = r_q;
endmodule

// File: rtl/resample_frame_sched.sv
// Ping-pong frame scheduler: fills one bin bank while reading the other out
// through a 3-stage zero-order-hold index pipeline, src = floor(k * scale).
//
// read FSM   | meaning
// RD_IDLE    | waiting for rd_bank to be full; latches sf_active on exit
// RD_RUN     | issuing k = 0..N-1 into the index pipeline
// RD_DRAIN   | last bin issued; waiting for its output beat to be taken
//
// Write side has no explicit state: fft_ready = !full[wr_bank]
// (ready = filling, low = both banks full).
module resample_frame_sched
   import resample_pkg::*;
#(
   parameter int XK_WIDTH      = XK_WIDTH_D,
   parameter int SF_INT_WIDTH  = SF_INT_WIDTH_D,
   parameter int SF_FRAC_WIDTH = SF_FRAC_WIDTH_D,
   parameter int DFT_WIDTH     = DFT_WIDTH_D
) (
   input  logic                    clock,
   input  logic                    reset_n,
   resample_frame_sched_if.slave   bus
);
   localparam int N    = 2**XK_WIDTH;
   localparam int SF_W = SF_INT_WIDTH + SF_FRAC_WIDTH;
   localparam int PW   = XK_WIDTH + SF_W;
   localparam int LW   = XK_WIDTH + 1;
   localparam logic [SF_W-1:0] SF_ONE = SF_W'(sf_one(SF_FRAC_WIDTH));

   logic [1:0]           r_full;
   logic [LW-1:0]        r_len [2];
   logic                 r_wr_bank;
   logic [XK_WIDTH-1:0]  r_wr_cnt;
   logic                 r_rd_bank;
   rd_state_t            r_rd_state;
   logic [XK_WIDTH-1:0]  r_k;
   logic [SF_W-1:0]      r_sf_pending;
   logic [SF_W-1:0]      r_sf_active;

   logic                 r_s1_valid, r_s1_last;
   logic [PW-1:0]        r_s1_prod;
   logic                 r_s2_valid, r_s2_last, r_s2_oob;
   logic                 r_m_valid, r_m_last;
   logic [DFT_WIDTH-1:0] r_m_data;

   logic                 w_fft_ready, w_in_fire, w_frame_end;
   logic                 w_adv, w_issue, w_out_done, w_rd_free, w_src_oob;
   logic [XK_WIDTH:0]    w_raddr;
   logic [DFT_WIDTH-1:0] w_ram_q;

   assign w_fft_ready = reset_n && !r_full[r_wr_bank];
   assign w_in_fire   = bus.fft_valid && w_fft_ready;
   assign w_frame_end = w_in_fire && (bus.fft_last || r_wr_cnt == XK_WIDTH'(N-1));
   assign w_adv       = !r_m_valid || bus.m_ready;
   assign w_issue     = (r_rd_state == RD_RUN) && w_adv;
   assign w_out_done  = r_m_valid && r_m_last && bus.m_ready;
   assign w_rd_free   = (r_rd_state == RD_DRAIN) && w_out_done;

   // floor(prod / 2^F) >= len  <=>  prod >= len * 2^F, so no source bits are dropped
   assign w_src_oob = r_s1_prod >= (PW'(r_len[r_rd_bank]) << SF_FRAC_WIDTH);
   assign w_raddr   = {r_rd_bank, r_s1_prod[SF_FRAC_WIDTH +: XK_WIDTH]};

   bin_ram #(.AW(XK_WIDTH + 1), .DW(DFT_WIDTH)) u_bin_ram (
      .clock   (clock),
      .i_we    (w_in_fire),
      .i_waddr ({r_wr_bank, r_wr_cnt}),
      .i_wdata (bus.fft_data),
      .i_re    (w_adv),
      .i_raddr (w_raddr),
      .o_q     (w_ram_q)
   );

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_full    <= '0;
         r_len     <= '{default: '0};
         r_wr_bank <= 1'b0;
         r_wr_cnt  <= '0;
      end else begin
         if (w_in_fire) begin
            if (w_frame_end) begin
               r_len[r_wr_bank] <= LW'(r_wr_cnt) + LW'(1);
               r_wr_cnt         <= '0;
               r_wr_bank        <= ~r_wr_bank;
            end else begin
               r_wr_cnt <= r_wr_cnt + XK_WIDTH'(1);
            end
         end
         // set and clear always target different banks
         if (w_frame_end) r_full[r_wr_bank] <= 1'b1;
         if (w_rd_free)   r_full[r_rd_bank] <= 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_rd_state   <= RD_IDLE;
         r_rd_bank    <= 1'b0;
         r_k          <= '0;
         r_sf_pending <= SF_ONE;
         r_sf_active  <= SF_ONE;
         r_s1_valid   <= 1'b0;
         r_s1_last    <= 1'b0;
         r_s1_prod    <= '0;
         r_s2_valid   <= 1'b0;
         r_s2_last    <= 1'b0;
         r_s2_oob     <= 1'b0;
         r_m_valid    <= 1'b0;
         r_m_last     <= 1'b0;
         r_m_data     <= '0;
      end else begin
         if (bus.scale_factor_valid) r_sf_pending <= bus.scale_factor;

         case (r_rd_state)
            RD_IDLE: if (r_full[r_rd_bank]) begin
               r_rd_state  <= RD_RUN;
               r_sf_active <= r_sf_pending;
               r_k         <= '0;
            end
            RD_RUN: if (w_adv) begin
               r_k <= r_k + XK_WIDTH'(1);
               if (r_k == XK_WIDTH'(N-1)) r_rd_state <= RD_DRAIN;
            end
            RD_DRAIN: if (w_out_done) begin
               r_rd_bank  <= ~r_rd_bank;
               r_rd_state <= RD_IDLE;
            end
            default: r_rd_state <= RD_IDLE;
         endcase

         if (w_adv) begin
            r_s1_valid <= w_issue;
            r_s1_last  <= (r_k == XK_WIDTH'(N-1));
            r_s1_prod  <= PW'(r_k) * PW'(r_sf_active);
            r_s2_valid <= r_s1_valid;
            r_s2_last  <= r_s1_last;
            r_s2_oob   <= w_src_oob;
            r_m_valid  <= r_s2_valid;
            r_m_last   <= r_s2_valid && r_s2_last;
            r_m_data   <= (r_s2_valid && !r_s2_oob) ? w_ram_q : '0;
         end
      end
   end

   assign bus.fft_ready = w_fft_ready;
   assign bus.m_valid   = r_m_valid;
   assign bus.m_last    = r_m_last;
   assign bus.m_data    = r_m_data;
endmodule

// File: tb/tb_resample_frame_sched.sv
// Directed bench for resample_frame_sched with N=16: a frame-level model predicts
// every output beat, checked each cycle, plus literal checks of key beats and timing.
module tb_resample_frame_sched;
   localparam int XK = 4;
   localparam int NB = 16;

   logic clock = 1'b0;
   logic reset_n;
   always #5 clock = ~clock;

   resample_frame_sched_if #(.DFT_WIDTH(24), .SF_WIDTH(20)) bus ();

   resample_frame_sched #(
      .XK_WIDTH(XK), .SF_INT_WIDTH(4), .SF_FRAC_WIDTH(16), .DFT_WIDTH(24)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef struct {
      logic [23:0] data;
      logic        last;
   } beat_t;

   beat_t       exp_q[$];
   logic [23:0] obs[$];
   int n_assert = 0;
   int n_fail   = 0;
   bit rnd_en   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Frame of bins base+i, length len, read out at scale sf (16 fraction bits)
   function automatic void push_frame(input int base, input int len, input longint sf);
      for (int k = 0; k < NB; k++) begin
         beat_t  b;
         longint src;
         src    = (longint'(k) * sf) >> 16;
         b.data = (src < len) ? 24'(base + src) : 24'd0;
         b.last = (k == NB - 1);
         exp_q.push_back(b);
      end
   endfunction

   // Compare process: every accepted beat against the model, and hold-stability under stall
   initial begin
      logic [23:0] hold_d;
      logic        hold_l;
      bit          holding;
      holding = 0;
      forever begin
         @(negedge clock);
         if (!reset_n) begin
            holding = 0;
            continue;
         end
         if (holding) begin
            check("stall_valid", 32'(bus.m_valid), 32'd1);
            check("stall_data", 32'(bus.m_data), 32'(hold_d));
            check("stall_last", 32'(bus.m_last), 32'(hold_l));
         end
         if (bus.m_valid && bus.m_ready) begin
            holding = 0;
            if (exp_q.size() == 0) begin
               check("unexpected_beat", 32'(bus.m_data), 32'hFFFF_FFFF);
            end else begin
               beat_t e;
               e = exp_q.pop_front();
               check("beat_data", 32'(bus.m_data), 32'(e.data));
               check("beat_last", 32'(bus.m_last), 32'(e.last));
               obs.push_back(bus.m_data);
            end
         end else if (bus.m_valid) begin
            holding = 1;
            hold_d  = bus.m_data;
            hold_l  = bus.m_last;
         end else begin
            holding = 0;
         end
      end
   end

   initial begin
      forever begin
         @(posedge clock);
         #1;
         if (rnd_en) bus.m_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish, expected end before 1ms");
      $fatal(1);
   end

   // Tasks below are entered and left at posedge+1
   task automatic send_beat(input logic [23:0] d, input bit last);
      int n;
      n = 0;
      bus.fft_valid = 1'b1;
      bus.fft_data  = d;
      bus.fft_last  = last;
      forever begin
         @(negedge clock);
         if (bus.fft_ready) break;
         n++;
         if (n > 2000) begin
            check("send_timeout", 32'(n), 32'd0);
            break;
         end
      end
      @(posedge clock);
      #1;
      bus.fft_valid = 1'b0;
      bus.fft_last  = 1'b0;
   endtask

   task automatic send_frame(input int base, input int len, input bit use_last);
      for (int i = 0; i < len; i++) send_beat(24'(base + i), use_last && (i == len - 1));
   endtask

   task automatic set_sf(input logic [19:0] v);
      bus.scale_factor       = v;
      bus.scale_factor_valid = 1'b1;
      @(posedge clock);
      #1;
      bus.scale_factor_valid = 1'b0;
   endtask

   task automatic wait_empty(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 1000) begin
         @(negedge clock);
         n++;
      end
      check(name, 32'(exp_q.size()), 32'd0);
      @(posedge clock);
      #1;
   endtask

   task automatic wait_m_valid(input string name);
      int n;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!bus.m_valid && n < 200);
      check(name, 32'(bus.m_valid), 32'd1);
      @(posedge clock);
      #1;
   endtask

   initial begin
      int n;
      bit got;
      reset_n = 1'b0;
      bus.scale_factor = '0;
      bus.scale_factor_valid = 1'b0;
      bus.fft_data = '0;
      bus.fft_valid = 1'b0;
      bus.fft_last = 1'b0;
      bus.m_ready = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      check("rst_fft_ready_low", 32'(bus.fft_ready), 32'd0);
      reset_n = 1'b1;
      @(negedge clock);
      check("rst_fft_ready_high", 32'(bus.fft_ready), 32'd1);
      check("rst_m_valid", 32'(bus.m_valid), 32'd0);
      check("rst_m_last", 32'(bus.m_last), 32'd0);
      check("rst_m_data", 32'(bus.m_data), 32'd0);
      @(posedge clock);
      #1;

      // Identity, implicit last on bin 15
      obs.delete();
      push_frame(0, 16, 64'h10000);
      send_frame(0, 16, 0);
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!bus.m_valid && n < 50);
      check("id_latency_edges", 32'(n - 1), 32'd4);
      @(posedge clock);
      #1;
      wait_empty("id_drain");
      check("id_count", 32'(obs.size()), 32'd16);
      check("id_beat15", 32'(obs[15]), 32'd15);

      // Half scale
      set_sf(20'h08000);
      obs.delete();
      push_frame(0, 16, 64'h08000);
      send_frame(0, 16, 1);
      wait_empty("half_drain");
      check("half_beat5", 32'(obs[5]), 32'd2);
      check("half_beat15", 32'(obs[15]), 32'd7);

      // Double scale: upper half falls past the frame
      set_sf(20'h20000);
      obs.delete();
      push_frame(0, 16, 64'h20000);
      send_frame(0, 16, 0);
      wait_empty("dbl_drain");
      check("dbl_beat7", 32'(obs[7]), 32'd14);
      check("dbl_beat8", 32'(obs[8]), 32'd0);
      check("dbl_beat15", 32'(obs[15]), 32'd0);

      // Ping-pong full with output stalled
      set_sf(20'h10000);
      obs.delete();
      bus.m_ready = 1'b0;
      push_frame(32'h100, 16, 64'h10000);
      push_frame(32'h200, 16, 64'h10000);
      push_frame(32'h300, 16, 64'h10000);
      send_frame(32'h100, 16, 0);
      send_frame(32'h200, 16, 1);
      @(negedge clock);
      check("pp_ready_drop", 32'(bus.fft_ready), 32'd0);
      repeat (5) @(negedge clock);
      check("pp_ready_held_low", 32'(bus.fft_ready), 32'd0);
      @(posedge clock);
      #1;
      bus.m_ready = 1'b1;
      fork
         begin
            n = 0;
            got = 0;
            while (n < 300 && !got) begin
               @(negedge clock);
               n++;
               if (bus.m_valid && bus.m_ready && bus.m_last) got = 1;
            end
            check("pp_last_seen", 32'(got), 32'd1);
            check("pp_ready_before_free", 32'(bus.fft_ready), 32'd0);
            @(negedge clock);
            check("pp_ready_return", 32'(bus.fft_ready), 32'd1);
         end
         send_frame(32'h300, 16, 0);
      join
      wait_empty("pp_drain");
      check("pp_count", 32'(obs.size()), 32'd48);
      check("pp_first_f2", 32'(obs[32]), 32'h300);

      // Random backpressure, half scale
      set_sf(20'h08000);
      obs.delete();
      push_frame(32'h400, 16, 64'h08000);
      push_frame(32'h500, 16, 64'h08000);
      rnd_en = 1;
      send_frame(32'h400, 16, 0);
      send_frame(32'h500, 16, 0);
      wait_empty("rnd_drain");
      rnd_en = 0;
      @(posedge clock);
      #1;
      bus.m_ready = 1'b1;
      check("rnd_beat17", 32'(obs[17]), 32'h500);

      // Scale change during readout, short second frame
      set_sf(20'h10000);
      obs.delete();
      push_frame(32'h600, 16, 64'h10000);
      push_frame(32'h700, 10, 64'h08000);
      send_frame(32'h600, 16, 0);
      wait_m_valid("mid_start");
      set_sf(20'h08000);
      send_frame(32'h700, 10, 1);
      wait_empty("mid_drain");
      check("mid_f0_beat15", 32'(obs[15]), 32'h60F);
      check("mid_f1_beat15", 32'(obs[31]), 32'h707);

      // Reset during readout; scale must revert to 1.0
      set_sf(20'h20000);
      obs.delete();
      push_frame(32'h800, 16, 64'h20000);
      send_frame(32'h800, 16, 0);
      wait_m_valid("rst_mid_start");
      repeat (3) @(posedge clock);
      #1;
      reset_n = 1'b0;
      exp_q.delete();
      @(posedge clock);
      #1;
      check("rstm_ready_low", 32'(bus.fft_ready), 32'd0);
      check("rstm_valid_low", 32'(bus.m_valid), 32'd0);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      @(negedge clock);
      check("rstm_valid_after", 32'(bus.m_valid), 32'd0);
      check("rstm_ready_after", 32'(bus.fft_ready), 32'd1);
      @(posedge clock);
      #1;
      obs.delete();
      push_frame(32'h900, 16, 64'h10000);
      send_frame(32'h900, 16, 0);
      wait_empty("rstm_drain");
      check("rstm_beat1", 32'(obs[1]), 32'h901);
      check("rstm_beat15", 32'(obs[15]), 32'h90F);

      repeat (5) @(posedge clock);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/resample_frame_sched.md
Name: resample_frame_sched

Overview:
- Ping-pong frame scheduler that sequences the zero-order-hold resampler.
- Captures each FFT output frame into one of two bin banks while the other bank is read out with rescaled source indices, src = floor(k * scale_factor).
- Sits between the FFT core output and the inverse-FFT input of the pitch shifter.
- Owns bank hand-off, scale-factor frame alignment and output AXI-stream-style handshaking.

Parameters:
- XK_WIDTH, 12: log2 of frame length; N = 2**XK_WIDTH bins.
- SF_INT_WIDTH, 4: integer bits of the unsigned scale factor.
- SF_FRAC_WIDTH, 16: fraction bits of the unsigned scale factor.
- DFT_WIDTH, 24: bin data width.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- scale_factor  in  SF_INT_WIDTH+SF_FRAC_WIDTH  unsigned fixed-point ratio.
- scale_factor_valid  in  1  strobe that loads scale_factor into the pending register.
- fft_data  in  DFT_WIDTH  input bin.
- fft_valid  in  1  input beat valid.
- fft_last  in  1  last bin of the input frame.
- fft_ready  out  1  scheduler can accept an input beat.
- m_data  out  DFT_WIDTH  resampled bin.
- m_valid  out  1  output beat valid.
- m_last  out  1  asserted with output bin k = N-1.
- m_ready  in  1  downstream accepts the output beat.

Behaviour:
- Reset (synchronous, reset_n=0), also when applied mid-operation:
  - both banks empty; wr_bank=0, rd_bank=0; write/read counters 0.
  - sf_pending = sf_active = 1.0 (1<<SF_FRAC_WIDTH).
  - fft_ready=0 during reset, 1 the first cycle after it.
  - m_valid=0, m_last=0, m_data=0.
  - Any partial frame in flight is discarded.
- Input beat accepted when fft_valid && fft_ready. The bin is written to bank[wr_bank][wr_cnt], and wr_cnt increments.
- Frame end occurs on an accepted beat with fft_last=1, or on an accepted beat with wr_cnt=N-1 (implicit last). On frame end:
  - len[wr_bank] = wr_cnt+1 (range 1..N).
  - full[wr_bank] is set, wr_cnt is cleared, wr_bank toggles.
- fft_ready = !full[wr_bank]. This gives a write FSM of WR_FILL (ready) and WR_BLOCKED (both banks full).
- Read FSM:
  - RD_IDLE -> RD_RUN when full[rd_bank]=1. On that transition: sf_active <= sf_pending, k <= 0.
  - RD_RUN issues k = 0..N-1.
  - After bin N-1 is issued: RD_DRAIN until that beat is accepted at the output, then full[rd_bank] clears, rd_bank toggles, and the FSM returns to RD_IDLE.
- Freeing and filling in the same cycle: a bank freed by the read side is visible to fft_ready on the next cycle. Set and clear of different banks in the same cycle are both honoured.
- Index pipeline:
  - Stage 1 registers product = k * sf_active, full width XK_WIDTH+SF_INT_WIDTH+SF_FRAC_WIDTH, unsigned.
  - src = product >> SF_FRAC_WIDTH, truncated toward zero.
  - oob = (src >= len[rd_bank]), evaluated on the full-width src, so there is no wrap.
  - Stage 2 issues the synchronous RAM read at src[XK_WIDTH-1:0] and carries oob and is_last.
  - Stage 3 output register: m_data = oob ? 0 : ram_q.
- Latency: 3 cycles from k issue to m_valid with no backpressure. Throughput is 1 bin per cycle.
- Backpressure: the whole pipeline, including the RAM read enable, advances only when !m_valid || m_ready. m_data, m_valid and m_last stay stable while m_valid && !m_ready. No beat is lost or duplicated.
- scale_factor_valid may arrive at any time; the last value wins. sf_active changes only at a read-frame start, never mid-frame.
- Scale factor 0: every output equals bin 0 (src=0).

Decomposition:
- Shared package (resample_pkg):
  - width constants derived from XK_WIDTH, SF_INT_WIDTH and SF_FRAC_WIDTH.
  - SF_ONE = 1<<SF_FRAC_WIDTH.
  - read FSM state encoding.
- One sub-module, bin_ram:
  - simple dual-port RAM, depth 2*N, width DFT_WIDTH, one write port, one read port with read enable and 1-cycle read latency.
  - address = {bank, index}.
  - infers block RAM.

Test Plan (XK_WIDTH=4, N=16, SF_FRAC_WIDTH=16):
- Identity:
  - Stimulus: scale_factor=0x10000; one frame with bins 0..15; m_ready=1.
  - Required: m_data 0..15, m_last only on the 16th beat, first m_valid 3 cycles after the read frame starts.
- Half scale:
  - Stimulus: scale_factor=0x08000.
  - Required: output 0,0,1,1,...,7,7.
- Double scale:
  - Stimulus: scale_factor=0x20000.
  - Required: output 0,2,4,...,14, then eight zeros; m_last on the 16th beat.
- Ping-pong full:
  - Stimulus: m_ready=0; stream three frames.
  - Required: fft_ready drops after the 32nd accepted bin. Then raise m_ready: fft_ready returns the cycle after frame 0's last beat is accepted. Frames emerge in order with no loss.
- Random m_ready toggling:
  - Required: output sequence identical to the m_ready=1 run; m_data held stable while stalled.
- Mid-frame scale change and short frame:
  - Stimulus: scale_factor=0x08000 written during frame 0 readout; frame 1 ends with fft_last on bin 9.
  - Required: frame 0 output unchanged. Frame 1 uses 0.5: src 0..7 return bins 0..7 (each value twice, k=0..15), with no zeros expected since src<10.
- Reset mid-stream:
  - Stimulus: reset_n=0 during frame readout.
  - Required: m_valid=0, fft_ready=1 the cycle after release, scale returns to 1.0.
